iccm_readback_tx: RTL

Reads a contiguous range of ICCM words and streams them out as bytes to the UART transmitter, the counterpart of the UART-to-ICCM loader. Each 32-bit word is split MSB-first, the same byte order in which the loader assembles words. After the range, an optional terminator word 32'h00000FFF is sent so a host can detect end of dump. It sits between the ICCM read port and the UART TX byte interface.

---
 rtl/iccm_readback_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/iccm_readback_tx.sv
// Streams a contiguous ICCM word range out as MSB-first bytes to a UART TX,
// optionally followed by the 32'h00000FFF end-of-dump terminator word.
module iccm_readback_tx #(
  parameter int ADDR_STEP = 2,
  parameter int SEND_TERM = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [13:0] base_addr_i,
  input  logic [13:0] word_count_i,
  output logic        re_o,
  output logic [13:0] raddr_o,
  input  logic [31:0] rdata_i,
  output logic        tx_dv_o,
  output logic [7:0]  tx_byte_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, TERM, FINISH} state_t;

  localparam logic [31:0] TERM_WORD = 32'h0000_0FFF;
  localparam logic [13:0] STEP      = 14'(ADDR_STEP);

  state_t      state;
  logic [13:0] addr;
  logic [13:0] remaining;
  logic [31:0] word;
  logic [1:0]  idx;
  logic [13:0] next_addr;

  assign next_addr = addr + STEP;

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    pick = w[31:24];
      2'd1:    pick = w[23:16];
      2'd2:    pick = w[15:8];
      default: pick = w[7:0];
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      idx       <= '0;
      re_o      <= 1'b0;
      raddr_o   <= '0;
      tx_dv_o   <= 1'b0;
      tx_byte_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      re_o   <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            addr      <= base_addr_i;
            remaining <= word_count_i;
            busy_o    <= 1'b1;
            idx       <= '0;
            if (word_count_i != '0) begin
              state   <= READ;
              re_o    <= 1'b1;
              raddr_o <= base_addr_i;
            end else if (SEND_TERM != 0) begin
              state     <= TERM;
              word      <= TERM_WORD;
              tx_dv_o   <= 1'b1;
              tx_byte_o <= TERM_WORD[31:24];
            end else begin
              state  <= FINISH;
              done_o <= 1'b1;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          // Present the first byte straight from the read port so SEND starts next cycle.
          word      <= rdata_i;
          idx       <= '0;
          tx_dv_o   <= 1'b1;
          tx_byte_o <= rdata_i[31:24];
          state     <= SEND;
        end
        SEND, TERM: begin
          if (tx_ready_i) begin
            if (idx != 2'd3) begin
              idx       <= idx + 2'd1;
              tx_byte_o <= pick(word, idx + 2'd1);
            end else begin
              tx_dv_o <= 1'b0;
              idx     <= '0;
              if (state == TERM) begin
                state  <= FINISH;
                done_o <= 1'b1;
              end else begin
                remaining <= remaining - 14'd1;
                addr      <= next_addr;
                if (remaining == 14'd1) begin
                  if (SEND_TERM != 0) begin
                    word      <= TERM_WORD;
                    tx_dv_o   <= 1'b1;
                    tx_byte_o <= TERM_WORD[31:24];
                    state     <= TERM;
                  end else begin
                    state  <= FINISH;
                    done_o <= 1'b1;
                  end
                end else begin
                  state   <= READ;
                  re_o    <= 1'b1;
                  raddr_o <= next_addr;
                end
              end
            end
          end
        end
        FINISH: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
